// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file with sweep clear.
// Optional hardwired-zero register 0 is enabled by defining REGFILE_MP_ZERO_REG_EN.
package regfile_mp_pkg;

    localparam int DEFAULT_N     = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} rf_state_t;

endpackage

// File: rtl/regfile_mp_clear_fsm.sv
// Sweep-clear sequencer: walks the array one entry per cycle and reports busy/done.
module regfile_mp_clear_fsm
    import regfile_mp_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr,
    output logic          clear_busy,
    output logic          clear_done
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     state, state_next;
    logic [AW-1:0] idx, idx_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: defaults are assigned first so no path through the case leaves a
    // combinational output unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        unique case (state)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                idx_next = idx + 1'b1;
                if (idx == LAST) begin
                    state_next = DONE;
                    idx_next   = '0;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign clear_busy = (state == CLEAR);
    assign clear_done = (state == DONE);
    assign clr_en     = clear_busy;
    assign clr_addr   = idx;

endmodule

// File: rtl/regfile_mp.sv
// Two-write / two-read register file with optional write-to-read bypass and sweep clear.
// Define REGFILE_MP_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter  int N      = DEFAULT_N,
    parameter  int DEPTH  = DEFAULT_DEPTH,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we3,
    input  logic [AW-1:0] wa3,
    input  logic [N-1:0]  wd3,
    input  logic          we4,
    input  logic [AW-1:0] wa4,
    input  logic [N-1:0]  wd4,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [N-1:0]  rd1,
    output logic [N-1:0]  rd2,
    input  logic          clear_req,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          wr_drop
);

    logic [N-1:0]  mem [DEPTH];
    logic          clr_en;
    logic [AW-1:0] clr_addr;
    logic          we3_eff, we4_eff;
    logic          we3_ok, we4_ok;

    regfile_mp_clear_fsm #(.DEPTH(DEPTH)) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .clr_en     (clr_en),
        .clr_addr   (clr_addr),
        .clear_busy (clear_busy),
        .clear_done (clear_done)
    );

`ifdef REGFILE_MP_ZERO_REG_EN
    assign we3_eff = we3 && (wa3 != '0);
    assign we4_eff = we4 && (wa4 != '0);
`else
    assign we3_eff = we3;
    assign we4_eff = we4;
`endif

    assign we3_ok = we3_eff && !clr_en;
    assign we4_ok = we4_eff && !clr_en;

    // NOTE: the array is reset on purpose: rst must zero every entry in a
    // single cycle, so this is a flop array rather than an inferred RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else begin
            if (we4_ok) mem[wa4] <= wd4;
            // Port A is scheduled last so it wins an address collision.
            if (we3_ok) mem[wa3] <= wd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                           wr_drop <= 1'b0;
        else if (clr_en && (we3_eff || we4_eff)) wr_drop <= 1'b1;
    end

    always_comb begin
        rd1 = mem[ra1];
        if (BYPASS != 0) begin
            if (we4_ok && (wa4 == ra1)) rd1 = wd4;
            if (we3_ok && (wa3 == ra1)) rd1 = wd3;
        end
    end

    always_comb begin
        rd2 = mem[ra2];
        if (BYPASS != 0) begin
            if (we4_ok && (wa4 == ra2)) rd2 = wd4;
            if (we3_ok && (wa3 == ra2)) rd2 = wd3;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a BYPASS=1 and a BYPASS=0 instance share stimulus.
// Expectations follow REGFILE_MP_ZERO_REG_EN when it is defined.
module tb_regfile_mp;

    localparam int N     = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

`ifdef REGFILE_MP_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          we3, we4, clear_req;
    logic [AW-1:0] wa3, wa4, ra1, ra2;
    logic [N-1:0]  wd3, wd4;
    logic [N-1:0]  rd1, rd2, rd1_nb, rd2_nb;
    logic          clear_busy, clear_done, wr_drop;
    logic          busy_nb, done_nb, drop_nb;

    int            errors = 0;
    int            checks = 0;
    logic [N-1:0]  sb [$];
    logic [N-1:0]  model [DEPTH];

    regfile_mp #(.N(N), .DEPTH(DEPTH), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .clear_done(clear_done), .wr_drop(wr_drop)
    );

    regfile_mp #(.N(N), .DEPTH(DEPTH), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .clear_req(clear_req), .clear_busy(busy_nb),
        .clear_done(done_nb), .wr_drop(drop_nb)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we3 = 1'b0;
        we4 = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [N-1:0] d);
        if (!(ZR && a == '0)) model[a] = d;
    endtask

    task automatic test_reset();
        logic [N-1:0] e;
        rst = 1'b1;
        idle_inputs();
        wa3 = '0; wa4 = '0; wd3 = '0; wd4 = '0;
        cycle();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        ra1 = 3'd3; ra2 = 3'd7;
        sb.push_back('0); sb.push_back('0);
        #1;
        e = sb.pop_front(); checks++;
        if (rd1 !== e) begin errors++; $display("FAIL reset rd1: got %h expected %h", rd1, e); end
        e = sb.pop_front(); checks++;
        if (rd2 !== e) begin errors++; $display("FAIL reset rd2: got %h expected %h", rd2, e); end
        checks++;
        if ({clear_busy, clear_done, wr_drop} !== 3'b000) begin
            errors++; $display("FAIL reset flags: got busy/done/drop=%b expected 000", {clear_busy, clear_done, wr_drop});
        end
        checks++;
        if ({busy_nb, done_nb, drop_nb} !== 3'b000) begin
            errors++; $display("FAIL reset flags nb: got %b expected 000", {busy_nb, done_nb, drop_nb});
        end
    endtask

    task automatic test_write_read();
        logic [N-1:0] e;
        cycle();
        we3 = 1'b1; wa3 = 3'd1; wd3 = 8'hAB;
        model_write(3'd1, 8'hAB);
        cycle();
        idle_inputs();
        ra1 = 3'd1; ra2 = 3'd4;
        sb.push_back(model[1]); sb.push_back(model[4]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd1 !== e) begin errors++; $display("FAIL write_read rd1: got %h expected %h", rd1, e); end
        e = sb.pop_front(); checks++;
        if (rd2 !== e) begin errors++; $display("FAIL write_read rd2: got %h expected %h", rd2, e); end
    endtask

    task automatic test_bypass();
        logic [N-1:0] e;
        cycle();
        we3 = 1'b1; wa3 = 3'd4; wd3 = 8'hFF; ra1 = 3'd4;
        sb.push_back(8'hFF); sb.push_back(model[4]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd1 !== e) begin errors++; $display("FAIL bypass same-cycle rd1: got %h expected %h", rd1, e); end
        e = sb.pop_front(); checks++;
        if (rd1_nb !== e) begin errors++; $display("FAIL nobypass same-cycle rd1: got %h expected %h", rd1_nb, e); end
        model_write(3'd4, 8'hFF);
        cycle();
        idle_inputs();
        sb.push_back(model[4]); sb.push_back(model[4]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd1 !== e) begin errors++; $display("FAIL bypass next-cycle rd1: got %h expected %h", rd1, e); end
        e = sb.pop_front(); checks++;
        if (rd1_nb !== e) begin errors++; $display("FAIL nobypass next-cycle rd1: got %h expected %h", rd1_nb, e); end
    endtask

    task automatic test_same_addr();
        logic [N-1:0] e;
        cycle();
        we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h11;
        we4 = 1'b1; wa4 = 3'd2; wd4 = 8'h22;
        ra2 = 3'd2;
        sb.push_back(8'h11); sb.push_back(model[2]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd2 !== e) begin errors++; $display("FAIL same_addr bypass rd2: got %h expected %h", rd2, e); end
        e = sb.pop_front(); checks++;
        if (rd2_nb !== e) begin errors++; $display("FAIL same_addr nobypass rd2: got %h expected %h", rd2_nb, e); end
        model_write(3'd2, 8'h11);
        cycle();
        // Two ports to distinct addresses in one cycle.
        we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h55;
        we4 = 1'b1; wa4 = 3'd6; wd4 = 8'h66;
        sb.push_back(model[2]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd2_nb !== e) begin errors++; $display("FAIL same_addr stored rd2: got %h expected %h", rd2_nb, e); end
        checks++;
        if (wr_drop !== 1'b0) begin errors++; $display("FAIL same_addr wr_drop: got %b expected 0", wr_drop); end
        model_write(3'd5, 8'h55);
        model_write(3'd6, 8'h66);
        cycle();
        idle_inputs();
        ra1 = 3'd5; ra2 = 3'd6;
        sb.push_back(model[5]); sb.push_back(model[6]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd1 !== e) begin errors++; $display("FAIL dual_write rd1: got %h expected %h", rd1, e); end
        e = sb.pop_front(); checks++;
        if (rd2 !== e) begin errors++; $display("FAIL dual_write rd2: got %h expected %h", rd2, e); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] e;
        for (int k = 1; k <= 3; k++) begin
            cycle();
            we3 = 1'b1; wa3 = 3'd1; wd3 = N'(k); ra1 = 3'd1;
            sb.push_back(N'(k)); sb.push_back(model[1]);
            #1;
            e = sb.pop_front(); checks++;
            if (rd1 !== e) begin errors++; $display("FAIL b2b[%0d] rd1: got %h expected %h", k, rd1, e); end
            e = sb.pop_front(); checks++;
            if (rd1_nb !== e) begin errors++; $display("FAIL b2b[%0d] rd1_nb: got %h expected %h", k, rd1_nb, e); end
            model_write(3'd1, N'(k));
        end
        cycle();
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        logic [N-1:0] e;
        cycle();
        we3 = 1'b1; wa3 = 3'd0; wd3 = 8'h5A; ra1 = 3'd0;
        sb.push_back(ZR ? 8'h00 : 8'h5A); sb.push_back(model[0]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd1 !== e) begin errors++; $display("FAIL zero_reg same-cycle rd1: got %h expected %h", rd1, e); end
        e = sb.pop_front(); checks++;
        if (rd1_nb !== e) begin errors++; $display("FAIL zero_reg same-cycle rd1_nb: got %h expected %h", rd1_nb, e); end
        model_write(3'd0, 8'h5A);
        cycle();
        idle_inputs();
        sb.push_back(model[0]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd1 !== e) begin errors++; $display("FAIL zero_reg next-cycle rd1: got %h expected %h", rd1, e); end
    endtask

    task automatic test_clear();
        logic [N-1:0] e;
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = -1;
        for (int i = 0; i < DEPTH; i += 2) begin
            cycle();
            we3 = 1'b1; wa3 = AW'(i);     wd3 = N'(8'h10 + i);
            we4 = 1'b1; wa4 = AW'(i + 1); wd4 = N'(8'h10 + i + 1);
            model_write(AW'(i), N'(8'h10 + i));
            model_write(AW'(i + 1), N'(8'h10 + i + 1));
        end
        cycle();
        idle_inputs();
        // Request the sweep with a write in the same IDLE cycle; the write must land.
        clear_req = 1'b1;
        we3 = 1'b1; wa3 = 3'd7; wd3 = 8'h77;
        model_write(3'd7, 8'h77);
        cycle();
        we3 = 1'b0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) cycle();
            if (c == 3) clear_req = 1'b0;
            if (c == 8) clear_req = 1'b1;
            if (c == 9) clear_req = 1'b0;
            if (c < DEPTH) begin
                ra1 = AW'(c);
                ra2 = (c == 0) ? 3'd7 : AW'(c - 1);
                sb.push_back(model[c]);
                sb.push_back((c == 0) ? model[7] : N'(0));
                #1;
                e = sb.pop_front(); checks++;
                if (rd1 !== e) begin errors++; $display("FAIL sweep[%0d] pending rd1: got %h expected %h", c, rd1, e); end
                e = sb.pop_front(); checks++;
                if (rd2 !== e) begin errors++; $display("FAIL sweep[%0d] cleared rd2: got %h expected %h", c, rd2, e); end
            end else begin
                #1;
            end
            if (clear_busy) busy_cnt++;
            if (clear_done) begin done_cnt++; done_at = c; end
        end
        checks++;
        if (busy_cnt != DEPTH) begin errors++; $display("FAIL sweep busy cycles: got %0d expected %0d", busy_cnt, DEPTH); end
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL sweep done pulses: got %0d expected 1", done_cnt); end
        checks++;
        if (done_at != DEPTH) begin errors++; $display("FAIL sweep done position: got %0d expected %0d", done_at, DEPTH); end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ra1 = AW'(a);
            sb.push_back(model[a]);
            #1;
            e = sb.pop_front(); checks++;
            if (rd1 !== e) begin errors++; $display("FAIL post_clear rd1[%0d]: got %h expected %h", a, rd1, e); end
        end
        checks++;
        if (wr_drop !== 1'b0) begin errors++; $display("FAIL post_clear wr_drop: got %b expected 0", wr_drop); end
    endtask

    task automatic test_drop_and_reset();
        logic [N-1:0] e;
        int stray = 0;
        cycle();
        we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h5A;
        we4 = 1'b1; wa4 = 3'd7; wd4 = 8'h71;
        model_write(3'd5, 8'h5A);
        model_write(3'd7, 8'h71);
        cycle();
        idle_inputs();
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) cycle();
            if (c == 3) begin
                we4 = 1'b1; wa4 = 3'd7; wd4 = 8'hEE; ra1 = 3'd7;
                sb.push_back(model[7]);
                #1;
                e = sb.pop_front(); checks++;
                if (rd1 !== e) begin errors++; $display("FAIL drop no-bypass rd1: got %h expected %h", rd1, e); end
            end else if (c == 4) begin
                we4 = 1'b0; ra1 = 3'd7; ra2 = 3'd5;
                sb.push_back(model[7]); sb.push_back(model[5]);
                #1;
                e = sb.pop_front(); checks++;
                if (rd1 !== e) begin errors++; $display("FAIL drop dropped rd1: got %h expected %h", rd1, e); end
                e = sb.pop_front(); checks++;
                if (rd2 !== e) begin errors++; $display("FAIL drop pending rd2: got %h expected %h", rd2, e); end
                checks++;
                if (wr_drop !== 1'b1) begin errors++; $display("FAIL drop wr_drop set: got %b expected 1", wr_drop); end
                checks++;
                if (drop_nb !== 1'b1) begin errors++; $display("FAIL drop wr_drop nb: got %b expected 1", drop_nb); end
            end else if (c == 5) begin
                #1;
                checks++;
                if ({clear_busy, wr_drop} !== 2'b11) begin
                    errors++; $display("FAIL drop sticky/busy: got busy/drop=%b expected 11", {clear_busy, wr_drop});
                end
                rst = 1'b1;
            end else begin
                #1;
            end
        end
        cycle();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        ra1 = 3'd7; ra2 = 3'd5;
        sb.push_back(model[7]); sb.push_back(model[5]);
        #1;
        e = sb.pop_front(); checks++;
        if (rd1 !== e) begin errors++; $display("FAIL abort rd1: got %h expected %h", rd1, e); end
        e = sb.pop_front(); checks++;
        if (rd2 !== e) begin errors++; $display("FAIL abort rd2: got %h expected %h", rd2, e); end
        checks++;
        if ({clear_busy, clear_done, wr_drop} !== 3'b000) begin
            errors++; $display("FAIL abort flags: got busy/done/drop=%b expected 000", {clear_busy, clear_done, wr_drop});
        end
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (clear_busy || clear_done) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL abort stray busy/done cycles: got %0d expected 0", stray); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_same_addr();
        test_back_to_back();
        test_zero_reg();
        test_clear();
        test_drop_and_reset();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the 8x8 single-write register file: width and depth are configurable, and it has two write ports, two combinational read ports and optional same-cycle write-to-read bypass.
- Adds a sequenced clear engine that zeroes the array one entry per cycle, with a busy/done handshake to the datapath controller.
- Sits in the datapath between the decode stage (which drives addresses) and the ALU (which consumes rd1/rd2).

Parameters:
- N, 8, data width in bits.
- DEPTH, 8, number of registers (power of two, at least 2); address width AW = $clog2(DEPTH), a localparam.
- BYPASS, 1, 1 = a read of an address being written this cycle returns the new data; 0 = it returns the stored value.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- we3  in  1  write enable, port A (higher priority).
- wa3  in  AW  write address, port A.
- wd3  in  N  write data, port A.
- we4  in  1  write enable, port B.
- wa4  in  AW  write address, port B.
- wd4  in  N  write data, port B.
- ra1  in  AW  read address 1.
- ra2  in  AW  read address 2.
- rd1  out  N  read data 1 (combinational).
- rd2  out  N  read data 2 (combinational).
- clear_req  in  1  start a sweep clear (single-cycle pulse or level).
- clear_busy  out  1  sweep in progress.
- clear_done  out  1  one-cycle pulse when the sweep completes.
- wr_drop  out  1  sticky flag: a write was dropped during a sweep.

Behaviour:
- Reset:
  - Synchronous, active-high; rst has priority over everything else.
  - On the rst edge, all registers go to 0, the FSM goes to IDLE, the sweep index goes to 0, and clear_busy, clear_done and wr_drop go to 0.
  - After reset, rd1 = rd2 = 0.
- Reads:
  - Asynchronous, zero latency: rdX = mem[raX].
  - With BYPASS=1, if weY is high and raX == waY, rdX = wdY. When both ports match, wd3 is forwarded.
- Writes:
  - Take effect on the rising clk edge and are visible from the next cycle.
  - Writes happen only in IDLE and DONE.
  - If we3 and we4 target the same address, wd3 is written and port B is discarded silently (not counted as a drop).
- FSM, states IDLE, CLEAR, DONE:
  - IDLE: clear_req=1 -> CLEAR with index 0. Writes in that same cycle still commit.
  - CLEAR: each cycle mem[index] <= 0 and index increments. On index == DEPTH-1 -> DONE. Occupies exactly DEPTH cycles.
  - DONE: lasts one cycle, then -> IDLE. clear_req in DONE is ignored.
  - clear_busy = 1 only in CLEAR. clear_done = 1 only in DONE.
  - clear_req while in CLEAR is ignored (no restart).
- Writes during CLEAR:
  - Dropped; any we3 or we4 during CLEAR sets wr_drop.
  - wr_drop stays set until rst.
- Reads during CLEAR:
  - Return current contents, which may be partially cleared.
  - Bypass is inactive during CLEAR, because no writes commit.
- Reset mid-sweep: rst aborts the sweep and zeroes the whole array in one cycle. No clear_done pulse is produced.

Optional Feature:
- Macro REGFILE_MP_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired to zero: writes to address 0 are discarded and not flagged.
  - Reads of address 0 return 0, including under bypass.
  - The sweep still takes DEPTH cycles.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package regfile_mp_pkg holds:
  - the FSM state enum: typedef enum logic [1:0] {IDLE, CLEAR, DONE} rf_state_t;
  - a default-width localparam.
- One sub-module, regfile_mp_clear_fsm, owns the state register, the sweep index, clear_busy and clear_done. It outputs clr_en and clr_addr to the array.
- The array, write arbitration and bypass muxes stay in the top module.

Test Plan:
- Reset, then we3=1, wa3=1, wd3=8'hAB; next cycle ra1=1 -> rd1=8'hAB; ra2=4 -> rd2=8'h00.
- BYPASS=1, same cycle we3=1, wa3=4, wd3=8'hFF, ra1=4 -> rd1=8'hFF immediately. With BYPASS=0 -> rd1=old value, then 8'hFF the next cycle.
- we3 and we4 both to address 2, wd3=8'h11, wd4=8'h22 -> mem[2]=8'h11; wr_drop stays 0.
- Fill all 8 registers with nonzero values, pulse clear_req -> clear_busy high for exactly 8 cycles, clear_done pulses once, then all reads return 0.
- we4=1 at sweep cycle 3 -> write dropped and wr_drop=1 until rst. Assert rst at sweep cycle 5 -> all registers 0 next cycle, clear_busy=0, no clear_done pulse.
- With REGFILE_MP_ZERO_REG_EN: we3=1, wa3=0, wd3=8'h5A; ra1=0 -> rd1=8'h00 in both the same and the next cycle.
